pocket_video_gen: RTL

//  Parametrised display-side video conditioner between the core video output and the APF scaler.

---
 rtl/pocket_video_pkg.sv | 46 ++++
 rtl/pocket_sync_pulse.sv | 34 +++
 rtl/pocket_video_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pocket_video_pkg.sv
// Shared types and helpers for the pocket video conditioner: pixel/pipeline structs,
// scaler-slot word layout and the colour-depth expansion function.
package pocket_video_pkg;

    localparam int OUT_BPC  = 8;
    localparam int SLOT_LSB = 3;
    localparam int SLOT_W   = 3;

    typedef struct packed {
        logic [OUT_BPC-1:0] r;
        logic [OUT_BPC-1:0] g;
        logic [OUT_BPC-1:0] b;
    } rgb24_t;

    typedef struct packed {
        rgb24_t rgb;
        logic   hs;
        logic   vs;
        logic   de;
    } pipe_t;

    // Sync fields come out of reset "asserted" so a sync held through reset release never looks like an edge.
    localparam pipe_t PIPE_RST = '{rgb: '0, hs: 1'b1, vs: 1'b1, de: 1'b0};

    function automatic rgb24_t slot_word(logic [SLOT_W-1:0] slot);
        rgb24_t w;
        w = '0;
        w[SLOT_LSB +: SLOT_W] = slot;
        return w;
    endfunction

    // Channel sits in c[bpc-1:0]; its bits are repeated MSB-first until 8 bits are filled.
    function automatic logic [OUT_BPC-1:0] expand_bpc(logic [7:0] c, int bpc);
        logic [OUT_BPC-1:0] r;
        logic [2:0]         srcIdx;
        logic [2:0]         dstIdx;
        r = '0;
        for (int i = 0; i < OUT_BPC; i++) begin
            srcIdx = 3'(bpc - 1 - (i % bpc));
            dstIdx = 3'(OUT_BPC - 1 - i);
            r[dstIdx] = c[srcIdx];
        end
        return r;
    endfunction

endpackage

// File: rtl/pocket_sync_pulse.sv
// Sync polarity normaliser plus rising-edge detector on the delayed, normalised sync.
// norm_o feeds the pipeline; dly_i is that same signal after the pipeline delay.
module pocket_sync_pulse
    import pocket_video_pkg::*;
#(
    parameter int POL = 1
) (
    input  logic clk_i,
    input  logic rstN_i,
    input  logic sync_i,
    output logic norm_o,
    input  logic dly_i,
    output logic edge_o,
    output logic pulse_o
);

    logic hist_q;
    logic pulse_q;

    assign norm_o  = sync_i ~^ POL[0];
    assign edge_o  = dly_i & ~hist_q;
    assign pulse_o = pulse_q;

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            hist_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= dly_i;
            pulse_q <= edge_o;
        end
    end

endmodule

// File: rtl/pocket_video_gen.sv
// Display-side video conditioner: aligned RGB/DE/sync delay, blanking, single-cycle sync pulses,
// optional scaler-slot word after each VS, and active width/height measurement.
module pocket_video_gen
    import pocket_video_pkg::*;
#(
    parameter int IN_BPC  = 8,
    parameter int DELAY   = 1,
    parameter int HS_POL  = 1,
    parameter int VS_POL  = 1,
    parameter int SLOT_EN = 0,
    parameter int HCNT_W  = 11,
    parameter int VCNT_W  = 10
) (
    input  logic                  iPCLK,
    input  logic                  iRST_N,
    input  logic                  iPCLK_90D,
    input  logic [3*IN_BPC-1:0]   iRGB,
    input  logic                  iHS,
    input  logic                  iVS,
    input  logic                  iDE,
    input  logic [2:0]            iSLOT,
    output logic [23:0]           oRGB,
    output logic                  oHS,
    output logic                  oVS,
    output logic                  oDE,
    output logic [HCNT_W-1:0]     oHACT,
    output logic [VCNT_W-1:0]     oVACT,
    output logic                  oMEAS_VLD,
    output logic                  oPCLK,
    output logic                  oPCLK_90D
);

    localparam logic [HCNT_W-1:0] HMAX = '1;
    localparam logic [VCNT_W-1:0] VMAX = '1;

    pipe_t  stageIn;
    pipe_t  stageOut;
    pipe_t  pipe_q [DELAY];
    logic   hsNorm, vsNorm, hsEdge, vsEdge;
    rgb24_t rgb_d, rgb_q;
    logic   de_q;

    logic [HCNT_W-1:0] hCount_d, hCount_q, hAct_d, hAct_q;
    logic [VCNT_W-1:0] vCount_d, vCount_q, vAct_d, vAct_q, vCountInc;
    logic              seenVs_d, seenVs_q, measVld_d, measVld_q, lineDone;

    pocket_sync_pulse #(.POL(HS_POL)) uHsPulse (
        .clk_i(iPCLK), .rstN_i(iRST_N), .sync_i(iHS), .norm_o(hsNorm),
        .dly_i(stageOut.hs), .edge_o(hsEdge), .pulse_o(oHS)
    );

    pocket_sync_pulse #(.POL(VS_POL)) uVsPulse (
        .clk_i(iPCLK), .rstN_i(iRST_N), .sync_i(iVS), .norm_o(vsNorm),
        .dly_i(stageOut.vs), .edge_o(vsEdge), .pulse_o(oVS)
    );

    always_comb begin
        stageIn.rgb.r = expand_bpc(8'(iRGB[2*IN_BPC +: IN_BPC]), IN_BPC);
        stageIn.rgb.g = expand_bpc(8'(iRGB[IN_BPC +: IN_BPC]), IN_BPC);
        stageIn.rgb.b = expand_bpc(8'(iRGB[0 +: IN_BPC]), IN_BPC);
        stageIn.hs    = hsNorm;
        stageIn.vs    = vsNorm;
        stageIn.de    = iDE;
    end

    assign stageOut = pipe_q[DELAY-1];

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < DELAY; i++) pipe_q[i] <= PIPE_RST;
        end else begin
            pipe_q[0] <= stageIn;
            for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // oVS is high during the pulse cycle, so the slot word lands in the following clock unless a pixel claims it.
    always_comb begin
        rgb_d = '0;
        if (stageOut.de) begin
            rgb_d = stageOut.rgb;
        end else if (SLOT_EN != 0 && oVS) begin
            rgb_d = slot_word(iSLOT);
        end
    end

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= stageOut.de;
        end
    end

    assign lineDone  = hsEdge && (hCount_q != '0);
    assign vCountInc = (vCount_q == VMAX) ? vCount_q : vCount_q + 1'b1;

    // A DE pixel coincident with an HS edge is the first pixel of the new line.
    always_comb begin
        hCount_d  = hCount_q;
        vCount_d  = vCount_q;
        hAct_d    = hAct_q;
        vAct_d    = vAct_q;
        seenVs_d  = seenVs_q;
        measVld_d = measVld_q;
        if (hsEdge) begin
            hCount_d = HCNT_W'(stageOut.de);
            if (lineDone) begin
                hAct_d   = hCount_q;
                vCount_d = vCountInc;
            end
        end else if (stageOut.de && hCount_q != HMAX) begin
            hCount_d = hCount_q + 1'b1;
        end
        if (vsEdge) begin
            vAct_d   = lineDone ? vCountInc : vCount_q;
            vCount_d = '0;
            seenVs_d = 1'b1;
            if (seenVs_q) measVld_d = 1'b1;
        end
    end

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hCount_q  <= '0;
            vCount_q  <= '0;
            hAct_q    <= '0;
            vAct_q    <= '0;
            seenVs_q  <= 1'b0;
            measVld_q <= 1'b0;
        end else begin
            hCount_q  <= hCount_d;
            vCount_q  <= vCount_d;
            hAct_q    <= hAct_d;
            vAct_q    <= vAct_d;
            seenVs_q  <= seenVs_d;
            measVld_q <= measVld_d;
        end
    end

    assign oRGB      = rgb_q;
    assign oDE       = de_q;
    assign oHACT     = hAct_q;
    assign oVACT     = vAct_q;
    assign oMEAS_VLD = measVld_q;
    assign oPCLK     = iPCLK;
    assign oPCLK_90D = iPCLK_90D;

endmodule
